// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-way arbitrating multiplexer with valid/ready
// handshakes on every input channel and on the single output stage.
//
// A round-robin pointer selects the starting channel of each scan. The winner's
// data and index are captured in one output register, which is refilled on the
// same edge it is drained, so a ready consumer sees one word per cycle.
//
// Build option:
//   RR_ARB_MUX_FIXED_PRIO_EN  - when defined, the pointer is removed and the
//                               lowest-index requesting channel always wins.
//                               The fairness bound no longer holds.
module rr_arb_mux #(
    parameter  int WIDTH = 8,
    parameter  int PORTS = 4,
    localparam int SELW  = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PORTS-1:0]       in_valid,
    input  logic [PORTS*WIDTH-1:0] in_data,
    output logic [PORTS-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_sel,
    input  logic                   out_ready
);

    // Channel count and last index at the widths used by the index arithmetic.
    localparam logic [SELW:0]   PORTS_W = (SELW + 1)'(PORTS);
    localparam logic [SELW-1:0] LAST_CH = SELW'(PORTS - 1);

    logic             load;       // output register may take a new word
    logic             take;       // a word is consumed from a channel this edge
    logic [SELW-1:0]  scan_base;  // first channel examined by the scan
    logic [PORTS-1:0] rot_req;    // requests rotated so scan_base sits at bit 0
    logic             gnt_found;
    logic [SELW-1:0]  gnt_off;    // winner's distance from scan_base
    logic [SELW:0]    gnt_sum;    // scan_base + gnt_off before the modulo wrap
    logic [SELW-1:0]  gnt_idx;    // absolute index of the winning channel
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid || out_ready;
    assign take = load && gnt_found && !RST;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    // Fixed priority: every scan starts at channel 0.
    assign scan_base = '0;
`else
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;

    assign scan_base = ptr;

    // Next scan starts just after the winner; the last channel wraps to 0 even
    // when PORTS is not a power of two.
    assign ptr_next = (gnt_idx == LAST_CH) ? '0 : gnt_idx + SELW'(1);

    // Round-robin pointer: advances only when a word is actually granted.
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= ptr_next;
        end
    end
`endif

    // Rotate the request vector so the scan becomes "lowest set bit wins".
    // Doubling the vector makes the rotation correct for any PORTS value.
    always_comb begin
        rot_req = PORTS'({in_valid, in_valid} >> scan_base);
    end

    // Priority scan over the rotated requests, then map back to a channel index.
    // NOTE: every variable gets a default before the loop so no path infers a latch;
    //       the descending loop lets the lowest set bit be the last (winning) write.
    always_comb begin
        gnt_found = 1'b0;
        gnt_off   = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                gnt_found = 1'b1;
                gnt_off   = SELW'(i);
            end
        end
        gnt_sum = {1'b0, scan_base} + {1'b0, gnt_off};
        if (gnt_sum >= PORTS_W) begin
            gnt_idx = SELW'(gnt_sum - PORTS_W);
        end else begin
            gnt_idx = SELW'(gnt_sum);
        end
    end

    // Data select for the winner; in_data never feeds back into in_ready.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt_idx == SELW'(i)) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot (or zero) acknowledge to the granted channel.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < PORTS; i++) begin
            in_ready[i] = take && (gnt_idx == SELW'(i));
        end
    end

    // Output stage: refill on load, hold under backpressure, drop valid when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            if (gnt_found) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_sel   <= gnt_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    // Handshake sanity: at most one channel acknowledged per cycle, and a held
    // word stays put until the consumer accepts it.
    a_ready_onehot0 : assert property (@(posedge CLK) $onehot0(in_ready));
    a_hold_stable   : assert property (@(posedge CLK) disable iff (RST)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: self-checking bench for rr_arb_mux. Two instances are driven
// from the same clock/reset: a 4-port one and a 3-port one (non-power-of-two).
// A behavioural model tracks the held word and the next scan start per instance
// and predicts the winner by modular distance from that start.
module tb_rr_arb_mux;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [3:0]  va;
    logic [31:0] da;
    logic        ra;
    logic [3:0]  rdy_a;
    logic        ova;
    logic [7:0]  oda;
    logic [1:0]  osa;

    logic [2:0]  vb;
    logic [23:0] db;
    logic        rb;
    logic [2:0]  rdy_b;
    logic        ovb;
    logic [7:0]  odb;
    logic [1:0]  osb;

    int n_cmp;
    int n_bad;

    // Model state: held word and the channel the next scan starts from.
    logic       ma_v, mb_v;
    logic [7:0] ma_d, mb_d;
    int         ma_s, mb_s;
    int         ma_start, mb_start;

    rr_arb_mux #(.WIDTH(8), .PORTS(4)) dut_a (
        .CLK(clk), .RST(rst),
        .in_valid(va), .in_data(da), .in_ready(rdy_a),
        .out_valid(ova), .out_data(oda), .out_sel(osa), .out_ready(ra)
    );

    rr_arb_mux #(.WIDTH(8), .PORTS(3)) dut_b (
        .CLK(clk), .RST(rst),
        .in_valid(vb), .in_data(db), .in_ready(rdy_b),
        .out_valid(ovb), .out_data(odb), .out_sel(osb), .out_ready(rb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Winner = requesting channel nearest to 'start' going upward modulo p.
    function automatic int pick(int p, int start, logic [15:0] req);
        int best;
        int s;
        best = -1;
        s = FIXED ? 0 : start;
        for (int d = 0; d < p; d++) begin
            int c;
            c = (s + d) % p;
            if (best < 0 && req[c]) best = c;
        end
        return best;
    endfunction

    function automatic logic [15:0] exp_ready(int p, logic mv, logic ordy, int start,
                                              logic [15:0] req, logic r);
        int g;
        if (r || (mv && !ordy)) return 16'h0;
        g = pick(p, start, req);
        if (g < 0) return 16'h0;
        return 16'(1) << g;
    endfunction

    // Apply the rules for one rising edge to both models.
    task automatic model_edge();
        int g;
        if (rst) begin
            ma_v = 1'b0; ma_d = 8'h00; ma_s = 0; ma_start = 0;
            mb_v = 1'b0; mb_d = 8'h00; mb_s = 0; mb_start = 0;
        end else begin
            if (!ma_v || ra) begin
                g = pick(4, ma_start, {12'h0, va});
                if (g >= 0) begin
                    ma_v = 1'b1; ma_d = 8'(da >> (8 * g)); ma_s = g; ma_start = (g + 1) % 4;
                end else begin
                    ma_v = 1'b0;
                end
            end
            if (!mb_v || rb) begin
                g = pick(3, mb_start, {13'h0, vb});
                if (g >= 0) begin
                    mb_v = 1'b1; mb_d = 8'(db >> (8 * g)); mb_s = g; mb_start = (g + 1) % 3;
                end else begin
                    mb_v = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        rst = 1'b1; va = 4'hF; vb = 3'h7; ra = 1'b1; rb = 1'b1;
        da = 32'h44332211; db = 24'h776655;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (rdy_a !== 4'h0 || rdy_b !== 3'h0) begin
                n_bad++;
                $display("FAIL reset_ready cyc%0d: got a=%b b=%b want 0", i, rdy_a, rdy_b);
            end
            tick();
        end
        rst = 1'b0; va = 4'h0; vb = 3'h0;
        #1;
        e = exp_ready(4, ma_v, ra, ma_start, {12'h0, va}, rst);
        n_cmp++;
        if (ova !== 1'b0 || oda !== 8'h00 || osa !== 2'd0 || ovb !== 1'b0 || odb !== 8'h00 || osb !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_out: got a v=%b d=%h s=%0d b v=%b d=%h s=%0d want all 0",
                     ova, oda, osa, ovb, odb, osb);
        end
        n_cmp++;
        if (rdy_a !== 4'(e)) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b want %b", rdy_a, 4'(e));
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] e;
        int          es;
        va = 4'hF; da = 32'hA3A2A1A0; ra = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            e = exp_ready(4, ma_v, ra, ma_start, {12'h0, va}, rst);
            es = FIXED ? 0 : (i % 4);
            n_cmp++;
            if (rdy_a !== 4'(e) || rdy_a !== 4'(1 << es)) begin
                n_bad++;
                $display("FAIL rr_ready cyc%0d: got %b want %b", i, rdy_a, 4'(1 << es));
            end
            tick();
            n_cmp++;
            if (ova !== 1'b1 || osa !== 2'(es) || oda !== 8'(8'hA0 + es) || osa !== 2'(ma_s)) begin
                n_bad++;
                $display("FAIL rr_out cyc%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, ova, osa, oda, es, 8'(8'hA0 + es));
            end
        end
    endtask

    task automatic test_backpressure();
        int held;
        va = 4'hF; ra = 1'b1; da = $urandom;
        tick();
        held = ma_s;
        ra = 1'b0;
        for (int i = 0; i < 5; i++) begin
            da = $urandom;
            #1;
            n_cmp++;
            if (rdy_a !== 4'h0) begin
                n_bad++;
                $display("FAIL bp_ready cyc%0d: got %b want 0000", i, rdy_a);
            end
            tick();
            n_cmp++;
            if (ova !== 1'b1 || osa !== 2'(held) || oda !== ma_d) begin
                n_bad++;
                $display("FAIL bp_hold cyc%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, ova, osa, oda, held, ma_d);
            end
        end
        ra = 1'b1;
        da = $urandom;
        tick();
        n_cmp++;
        if (osa !== 2'(FIXED ? 0 : (held + 1) % 4) || oda !== ma_d || ova !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got s=%0d d=%h want s=%0d d=%h",
                     osa, oda, FIXED ? 0 : (held + 1) % 4, ma_d);
        end
    endtask

    task automatic test_sparse();
        logic [15:0] e;
        va = 4'b1010; ra = 1'b1;
        for (int i = 0; i < 6; i++) begin
            da = $urandom;
            #1;
            e = exp_ready(4, ma_v, ra, ma_start, {12'h0, va}, rst);
            n_cmp++;
            if (rdy_a !== 4'(e)) begin
                n_bad++;
                $display("FAIL sparse_ready cyc%0d: got %b want %b", i, rdy_a, 4'(e));
            end
            tick();
            n_cmp++;
            if (ova !== 1'b1 || osa[0] !== 1'b1 || osa !== 2'(ma_s) || oda !== ma_d) begin
                n_bad++;
                $display("FAIL sparse_out cyc%0d: got s=%0d d=%h want s=%0d d=%h",
                         i, osa, oda, ma_s, ma_d);
            end
        end
    endtask

    task automatic test_ports3();
        logic [15:0] e;
        int          es;
        va = 4'h0; vb = 3'h7; rb = 1'b1;
        for (int i = 0; i < 7; i++) begin
            db = 24'($urandom);
            #1;
            e = exp_ready(3, mb_v, rb, mb_start, {13'h0, vb}, rst);
            n_cmp++;
            if (rdy_b !== 3'(e)) begin
                n_bad++;
                $display("FAIL p3_ready cyc%0d: got %b want %b", i, rdy_b, 3'(e));
            end
            tick();
            es = FIXED ? 0 : (i % 3);
            n_cmp++;
            if (ovb !== 1'b1 || osb !== 2'(es) || osb !== 2'(mb_s) || odb !== mb_d) begin
                n_bad++;
                $display("FAIL p3_out cyc%0d: got s=%0d d=%h want s=%0d d=%h",
                         i, osb, odb, es, mb_d);
            end
        end
        vb = 3'h0;
    endtask

    task automatic test_drop_ch0();
        logic [15:0] e;
        ra = 1'b1;
        for (int i = 0; i < 6; i++) begin
            va = (i < 3) ? 4'hF : 4'hE;
            da = $urandom;
            #1;
            e = exp_ready(4, ma_v, ra, ma_start, {12'h0, va}, rst);
            n_cmp++;
            if (rdy_a !== 4'(e)) begin
                n_bad++;
                $display("FAIL drop_ready cyc%0d: got %b want %b", i, rdy_a, 4'(e));
            end
            tick();
            n_cmp++;
            if (osa !== 2'(ma_s) || oda !== ma_d || (i >= 3 && osa === 2'd0)) begin
                n_bad++;
                $display("FAIL drop_out cyc%0d: got s=%0d d=%h want s=%0d d=%h",
                         i, osa, oda, ma_s, ma_d);
            end
        end
    endtask

    task automatic test_reset_mid();
        va = 4'hF; ra = 1'b1; da = $urandom;
        tick();
        ra = 1'b0; rst = 1'b1;
        #1;
        n_cmp++;
        if (rdy_a !== 4'h0) begin
            n_bad++;
            $display("FAIL rstmid_ready: got %b want 0000", rdy_a);
        end
        tick();
        n_cmp++;
        if (ova !== 1'b0 || oda !== 8'h00 || osa !== 2'd0) begin
            n_bad++;
            $display("FAIL rstmid_out: got v=%b d=%h s=%0d want 0/00/0", ova, oda, osa);
        end
        rst = 1'b0; ra = 1'b1;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstmid_first_grant: got %b want 0001", rdy_a);
        end
        tick();
        n_cmp++;
        if (ova !== 1'b1 || osa !== 2'd0 || oda !== da[7:0]) begin
            n_bad++;
            $display("FAIL rstmid_first_out: got v=%b s=%0d d=%h want 1/0/%h", ova, osa, oda, da[7:0]);
        end
    endtask

    task automatic test_random();
        logic [15:0] ea, eb;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(39) == 0);
            va  = 4'($urandom);
            vb  = 3'($urandom);
            da  = $urandom;
            db  = 24'($urandom);
            ra  = ($urandom_range(3) != 0);
            rb  = ($urandom_range(3) != 0);
            #1;
            ea = exp_ready(4, ma_v, ra, ma_start, {12'h0, va}, rst);
            eb = exp_ready(3, mb_v, rb, mb_start, {13'h0, vb}, rst);
            n_cmp++;
            if (rdy_a !== 4'(ea) || rdy_b !== 3'(eb)) begin
                n_bad++;
                $display("FAIL rand_ready cyc%0d: got a=%b b=%b want a=%b b=%b",
                         i, rdy_a, rdy_b, 4'(ea), 3'(eb));
            end
            tick();
            n_cmp++;
            if (ova !== ma_v || oda !== ma_d || osa !== 2'(ma_s)) begin
                n_bad++;
                $display("FAIL rand_out_a cyc%0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                         i, ova, oda, osa, ma_v, ma_d, ma_s);
            end
            n_cmp++;
            if (ovb !== mb_v || odb !== mb_d || osb !== 2'(mb_s)) begin
                n_bad++;
                $display("FAIL rand_out_b cyc%0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                         i, ovb, odb, osb, mb_v, mb_d, mb_s);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        ma_v = 1'b0; ma_d = 8'h00; ma_s = 0; ma_start = 0;
        mb_v = 1'b0; mb_d = 8'h00; mb_s = 0; mb_start = 0;
        rst = 1'b1; va = 4'h0; vb = 3'h0; da = '0; db = '0; ra = 1'b0; rb = 1'b0;

        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_ports3();
        test_drop_ch0();
        test_reset_mid();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised, registered N-way arbitrating multiplexer with valid/ready handshakes on every input and on the output. It selects one requesting input per cycle with a round-robin pointer and registers the winner's data and index into a single output stage. It sits between multiple producers (bus masters, I/O sources, interrupt/trap paths) and a single shared consumer in the MCU datapath. It replaces hard-wired select-driven muxes wherever the select would otherwise be decided by ad-hoc control logic.

## Interface
- `WIDTH`, default 8: data width of each channel and of the output.
- `PORTS`, default 4: number of input channels; legal range 1..16, not required to be a power of two.
- Select width is derived internally: SELW = max(1, $clog2(PORTS)); it is not a parameter.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- `CLK`  in  1  rising-edge clock; all state updates on this edge.
- `RST`  in  1  synchronous, active-high reset.
- `in_valid`  in  PORTS  per-channel request; bit i belongs to channel i.
- `in_data`  in  PORTS*WIDTH  flattened channel data; channel i occupies [i*WIDTH +: WIDTH].
- `in_ready`  out  PORTS  combinational, one-hot or zero; bit i high means channel i's word is taken this edge.
- `out_valid`  out  1  registered; the output register holds a word.
- `out_data`  out  WIDTH  registered data of the held word.
- `out_sel`  out  SELW  registered index of the channel that supplied the held word.
- `out_ready`  in  1  consumer accepts the held word on this edge when out_valid=1.

## Operation
- Load enable: load = !out_valid || out_ready.
- Arbitration, when load=1:
  - Scan channels ptr, ptr+1, ..., wrapping modulo PORTS (PORTS-1 wraps to 0, including for non-power-of-two PORTS).
  - The first channel with in_valid=1 is the grant g.
  - in_ready[g]=1; all other in_ready bits are 0.
- On the edge with load=1 and a grant present:
  - out_data <= channel g data; out_sel <= g; out_valid <= 1.
  - ptr <= (g+1) mod PORTS.
- On the edge with load=1 and no request: out_valid <= 0; out_data, out_sel and ptr hold.
- When load=0 (out_valid=1, out_ready=0): in_ready = 0; out_valid, out_data, out_sel and ptr hold, stable until accepted.
- Simultaneous accept and refill (out_valid=1, out_ready=1, new request present): the old word is consumed and the new word is loaded on the same edge, so there is no bubble.
- Input-side contract: a channel may drop in_valid or change in_data before it is granted; the block does not require held requests.
- PORTS=1: ptr is a constant 0, out_sel=0, and the block degenerates to a one-stage pipeline register.
- `in_ready` depends combinationally on in_valid, out_valid and out_ready; there is no path from in_data to in_ready.

## Timing
- Latency: 1 cycle from the granting edge to out_valid/out_data/out_sel.
- Throughput: one word per cycle when out_ready is held at 1.
- Fairness: any channel with in_valid held continuously is granted within PORTS loads.
- Reset (RST=1 at an edge) sets out_valid=0, out_data=0, out_sel=0, ptr=0.
- While RST=1, in_ready is forced to 0, so no word is consumed during reset.
- Reset mid-transfer discards any held word; the consumer must not see it after reset.
- First grant after reset starts the scan at channel 0.

## Configuration
- `RR_ARB_MUX_FIXED_PRIO_EN` defined:
  - ptr logic is compiled out.
  - The lowest-index requesting channel always wins (channel 0 has highest priority).
  - The fairness guarantee does not apply.
- Not defined (default): round-robin as specified above.

## Test plan
- Reset: assert RST for 2 cycles with all in_valid=1 -> in_ready=0 throughout; after release out_valid=0, out_data=0, out_sel=0.
- Round-robin: PORTS=4, WIDTH=8, all in_valid=1, data 0xA0..0xA3, out_ready=1 -> out_sel sequence 0,1,2,3,0, data matching, one word per cycle.
- Backpressure: hold out_ready=0 for 5 cycles after the first load -> out_data/out_sel stable, in_ready=0; release -> the next grant goes to (held sel+1) mod 4.
- Sparse requests: only channels 1 and 3 valid -> out_sel alternates 1,3,1,3; channels 0 and 2 are never granted.
- Non-power-of-two: PORTS=3, all valid -> out_sel 0,1,2,0 (ptr wraps from 2 to 0).
- Fixed priority: build with RR_ARB_MUX_FIXED_PRIO_EN, all valid -> out_sel stays 0 every cycle; drop in_valid[0] -> out_sel becomes 1.
